// File: rtl/idc_transpose_if.sv
// idc_transpose_if: pixel stream into the transposer and emitted frame plus status out.
interface idc_transpose_if;
  logic              in_valid;
  logic signed [6:0] in_data;
  logic              out_valid;
  logic signed [6:0] out_data;
  logic signed [10:0] out_sum;
  logic              drop;
  modport master (output in_valid, in_data, input out_valid, out_data, out_sum, drop);
  modport slave  (input in_valid, in_data, output out_valid, out_data, out_sum, drop);
endinterface

// File: rtl/idc_transpose.sv
// idc_transpose: captures a 4x4 pixel frame and re-emits it column-major (or row-major).
// Optional frame-sum accumulator enabled by defining IDC_TRANSPOSE_SUM_EN.
module idc_transpose #(
  parameter int TRANSPOSE = 1
) (
  input logic           clk,
  input logic           rst_n,
  idc_transpose_if.slave s
);
  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;
  state_t            state;
  logic [3:0]        k;
  logic [4:0]        m;
  logic signed [6:0] mem [16];
  logic              out_valid_q;
  logic signed [6:0] out_data_q;
  logic              drop_q;
  logic [3:0]        rd_idx;
  // buffer is stored flat in capture order; transposing just swaps the index halves
  assign rd_idx = (TRANSPOSE != 0) ? {m[1:0], m[3:2]} : m[3:0];
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.drop      = drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      m           <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          if (s.in_valid) begin
            mem[0] <= s.in_data;
            k      <= 4'd1;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (s.in_valid) begin
            mem[k] <= s.in_data;
            if (k == 4'd15) begin
              // element 0 is first in either order and is already stored
              state       <= EMIT;
              out_valid_q <= 1'b1;
              out_data_q  <= mem[0];
              m           <= 5'd1;
              k           <= '0;
            end else begin
              k <= k + 4'd1;
            end
          end else begin
            state  <= IDLE;
            k      <= '0;
            drop_q <= 1'b1;
          end
        end
        EMIT: begin
          drop_q <= s.in_valid;
          if (m == 5'd16) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            m           <= '0;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem[rd_idx];
            m           <= m + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef IDC_TRANSPOSE_SUM_EN
  logic signed [10:0] acc;
  logic signed [10:0] sum_q;
  logic signed [10:0] samp;
  assign samp = {{4{s.in_data[6]}}, s.in_data};
  assign s.out_sum = sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sum_q <= '0;
    end else if (state == IDLE && s.in_valid) begin
      acc <= samp;
    end else if (state == CAPTURE) begin
      acc <= s.in_valid ? acc + samp : '0;
      if (s.in_valid && k == 4'd15) sum_q <= acc + samp;
    end
  end
`else
  assign s.out_sum = '0;
`endif
endmodule

// File: tb/tb_idc_transpose.sv
// tb_idc_transpose: table vectors, corner sequences and random traffic against a queue model.
module tb_idc_transpose;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv = 1'b0;
  logic signed [6:0] id = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  idc_transpose_if t_if ();
  idc_transpose_if r_if ();
  assign t_if.in_valid = iv;
  assign t_if.in_data  = id;
  assign r_if.in_valid = iv;
  assign r_if.in_data  = id;

  idc_transpose #(.TRANSPOSE(1)) dut_t (.clk(clk), .rst_n(rst_n), .s(t_if.slave));
  idc_transpose #(.TRANSPOSE(0)) dut_r (.clk(clk), .rst_n(rst_n), .s(r_if.slave));

  // reference model: pending capture list, and the two emit sequences still to be shown
  logic signed [6:0] cap[$];
  logic signed [6:0] emq_t[$];
  logic signed [6:0] emq_r[$];
  int exp_sum = 0;
  logic exp_drop = 1'b0;
  logic exp_v = 1'b0;
  logic signed [6:0] exp_dt = '0;
  logic signed [6:0] exp_dr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap.delete(); emq_t.delete(); emq_r.delete();
      exp_sum = 0; exp_drop = 1'b0;
    end else begin
      exp_drop = 1'b0;
      if (emq_t.size() > 0) begin
        exp_drop = iv;
        void'(emq_t.pop_front());
        void'(emq_r.pop_front());
      end else if (iv) begin
        cap.push_back(id);
        if (cap.size() == 16) begin
          int s;
          s = 0;
          for (int j = 0; j < 16; j++) begin
            emq_t.push_back(cap[(j % 4) * 4 + j / 4]);
            emq_r.push_back(cap[j]);
            s += int'(cap[j]);
          end
`ifdef IDC_TRANSPOSE_SUM_EN
          exp_sum = s;
`endif
          cap.delete();
        end
      end else if (cap.size() > 0) begin
        exp_drop = 1'b1;
        cap.delete();
      end
    end
    exp_v  = emq_t.size() > 0;
    exp_dt = exp_v ? emq_t[0] : 7'sd0;
    exp_dr = exp_v ? emq_r[0] : 7'sd0;
  end

  always @(negedge clk) begin
    checks++;
    if (t_if.out_valid !== exp_v || t_if.out_data !== exp_dt || t_if.drop !== exp_drop ||
        int'(t_if.out_sum) != exp_sum) begin
      errors++;
      $display("FAIL cycle_t @%0t: got v=%b d=%0d drop=%b sum=%0d expected v=%b d=%0d drop=%b sum=%0d",
               $time, t_if.out_valid, t_if.out_data, t_if.drop, t_if.out_sum, exp_v, exp_dt, exp_drop, exp_sum);
    end
    checks++;
    if (r_if.out_valid !== exp_v || r_if.out_data !== exp_dr || r_if.drop !== exp_drop ||
        int'(r_if.out_sum) != exp_sum) begin
      errors++;
      $display("FAIL cycle_r @%0t: got v=%b d=%0d drop=%b sum=%0d expected v=%b d=%0d drop=%b sum=%0d",
               $time, r_if.out_valid, r_if.out_data, r_if.drop, r_if.out_sum, exp_v, exp_dr, exp_drop, exp_sum);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  logic signed [6:0] got_t[16];
  logic signed [6:0] got_r[16];

  task automatic drive_frame(input logic signed [6:0] base, input logic signed [6:0] step);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      iv = 1'b1;
      id = 7'(int'(base) + int'(step) * i);
    end
  endtask

  task automatic collect(input int inj_at, input int inj_n, output int drops);
    drops = 0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) begin
        got_t[i] = t_if.out_data;
        got_r[i] = r_if.out_data;
      end
      drops += int'(t_if.drop);
      iv = (i >= inj_at && i < inj_at + inj_n);
      id = 7'($urandom);
    end
  endtask

  typedef struct {
    logic signed [6:0] base;
    logic signed [6:0] step;
    int t1;
    int r1;
    int t15;
    int sum;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int dr;
    int exp_s;
    vecs[0] = '{7'sd0,   7'sd1,  4,   1,   15,  120};
    vecs[1] = '{-7'sd64, 7'sd0,  -64, -64, -64, -1024};
    vecs[2] = '{7'sd63,  7'sd0,  63,  63,  63,  1008};
    vecs[3] = '{-7'sd8,  7'sd1,  -4,  -7,  7,   -8};
    vecs[4] = '{7'sd10,  -7'sd1, 6,   9,   -5,  40};

    repeat (3) @(negedge clk);
    chk("reset_valid", int'(t_if.out_valid), 0);
    chk("reset_sum", int'(t_if.out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      drive_frame(vecs[n].base, vecs[n].step);
      collect(0, 0, dr);
`ifdef IDC_TRANSPOSE_SUM_EN
      exp_s = vecs[n].sum;
`else
      exp_s = 0;
`endif
      chk($sformatf("vec%0d_t_m1", n), int'(got_t[1]), vecs[n].t1);
      chk($sformatf("vec%0d_r_m1", n), int'(got_r[1]), vecs[n].r1);
      chk($sformatf("vec%0d_t_m15", n), int'(got_t[15]), vecs[n].t15);
      chk($sformatf("vec%0d_sum", n), int'(t_if.out_sum), exp_s);
      chk($sformatf("vec%0d_drops", n), dr, 0);
    end

    for (int i = 0; i < 16; i++) drive_frame_check: begin end
    drive_frame(7'sd0, 7'sd1);
    collect(0, 0, dr);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ramp_t_m%0d", i), int'(got_t[i]), (i % 4) * 4 + i / 4);
      chk($sformatf("ramp_r_m%0d", i), int'(got_r[i]), i);
    end

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      iv = 1'b1;
      id = 7'(i + 20);
    end
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    chk("abort_drop", int'(t_if.drop), 1);
    chk("abort_valid", int'(t_if.out_valid), 0);
    @(negedge clk);
    chk("abort_drop_once", int'(t_if.drop), 0);
    drive_frame(7'sd5, 7'sd2);
    collect(0, 0, dr);
    chk("after_abort_t_m0", int'(got_t[0]), 5);
    chk("after_abort_t_m1", int'(got_t[1]), 13);

    drive_frame(-7'sd3, 7'sd3);
    collect(2, 3, dr);
    chk("emit_inj_drops", dr, 3);
    chk("emit_inj_r_m4", int'(got_r[4]), 9);
    drive_frame(7'sd1, 7'sd1);
    collect(0, 0, dr);
    chk("post_inj_r_m0", int'(got_r[0]), 1);
    chk("post_inj_t_m1", int'(got_t[1]), 5);

    drive_frame(7'sd7, 7'sd1);
    @(negedge clk);
    iv = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", int'(t_if.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(t_if.out_valid), 0);
    chk("rst_data", int'(t_if.out_data), 0);
    chk("rst_sum", int'(t_if.out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_resume", int'(t_if.out_valid), 0);
    drive_frame(-7'sd20, 7'sd2);
    collect(0, 0, dr);
    chk("post_rst_t_m1", int'(got_t[1]), -12);
    chk("post_rst_r_m15", int'(got_r[15]), 10);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      iv = ($urandom_range(0, 11) != 0);
      id = 7'($urandom);
    end
    @(negedge clk);
    iv = 1'b0;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/idc_transpose.md
IDC_TRANSPOSE -- requirements
Module: idc_transpose

Interface
REQ-001 Parameter: TRANSPOSE, default 1; 1 = column-major emit order, 0 = row-major (capture order) emit.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  qualifies in_data; driven by upstream IDC out_valid.
REQ-005 in_data  input  7  signed pixel sample; driven by upstream IDC out_data.
REQ-006 out_valid  output  1  registered; high for exactly 16 consecutive cycles per emitted frame.
REQ-007 out_data  output  7  signed registered pixel; 0 whenever out_valid is low.
REQ-008 out_sum  output  11  signed frame sum (see Configuration).
REQ-009 drop  output  1  registered one-cycle pulse on overrun or aborted frame.

Function
REQ-010 States SHALL be IDLE, CAPTURE and EMIT; no other states reachable.
REQ-011 IDLE: in_valid=1 -> store sample as index k=0, go CAPTURE; else stay IDLE.
REQ-012 CAPTURE: each in_valid=1 cycle stores sample k into buf[k>>2][k&3], k increments 0..15.
REQ-013 Once sample k=15 is stored, the FSM SHALL go to EMIT on that same edge.
REQ-014 CAPTURE with in_valid=0 (gap, k<16) SHALL abort: buffer contents discarded, k=0, state IDLE, drop=1 the following cycle.
REQ-015 EMIT: out_valid=1 on 16 consecutive cycles, the first on the cycle after the edge storing k=15 (latency 1 cycle).
REQ-016 Emit index m=0..15: TRANSPOSE=1 outputs buf[m&3][m>>2]; TRANSPOSE=0 outputs buf[m>>2][m&3].
REQ-017 After m=15, the FSM SHALL return to IDLE; out_valid=0 the next cycle.
REQ-018 in_valid=1 during any EMIT cycle SHALL be ignored (not stored) and SHALL pulse drop=1 the following cycle, once per such cycle.
REQ-019 A sample arriving the cycle after m=15 (state IDLE) SHALL be accepted as k=0 of the next frame; back-to-back frames need no idle gap beyond EMIT.
REQ-020 Samples stored bit-exact; no arithmetic on pixel values.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, k=0, m=0, buffer=0, out_valid=0, out_data=0, out_sum=0, drop=0.
REQ-022 Reset asserted mid-CAPTURE or mid-EMIT SHALL discard the frame; no further outputs of that frame after deassertion.
REQ-023 First sample accepted is at the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-024 Macro IDC_TRANSPOSE_SUM_EN defined: an 11-bit signed accumulator adds each stored sample (sign-extended) during CAPTURE, cleared at k=0 and on abort.
REQ-025 With IDC_TRANSPOSE_SUM_EN, out_sum SHALL load the full 16-sample sum on the edge where out_valid first rises and hold it until the next frame's first output; range -1024..1008, no overflow.
REQ-026 Without IDC_TRANSPOSE_SUM_EN, no accumulator SHALL be synthesized and out_sum SHALL be constant 0.

Verification
REQ-027 Frame in_data=0,1,..,15, TRANSPOSE=1 -> out_data 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, first out_valid one cycle after sample 15.
REQ-028 Same frame, TRANSPOSE=0 -> out_data 0..15 in order; with SUM_EN out_sum=120, else 0.
REQ-029 16 samples all -64 with SUM_EN -> out_sum=-1024, all out_data=-64.
REQ-030 in_valid drops after 7 samples -> drop=1 one cycle, no out_valid; next 16-sample frame emits correctly.
REQ-031 in_valid=1 for 3 cycles during EMIT -> 3 drop pulses, emitted data unchanged, those samples absent from next frame.
REQ-032 rst_n pulsed low at emit m=5 -> out_valid=0 immediately, out_sum=0; next full frame emits correctly.
